bus_master_mux: RTL and testbench

//  Master-side multiplexer of the 4-master shared bus. Forwards address, r/w, address

---
 rtl/bus_master_mux_pkg.sv | 30 +++
 rtl/bus_master_mux.sv | 83 ++++++++
 tb/tb_bus_master_mux.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bus_master_mux_pkg.sv
// Shared bus definitions for the 4-master bus: widths, active levels
// and the bundle of fields a master drives onto the shared lines.
package bus_master_mux_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  localparam logic GRANT_ENABLE  = 1'b0;
  localparam logic GRANT_DISABLE = 1'b1;
  localparam logic AS_ENABLE     = 1'b0;
  localparam logic AS_DISABLE    = 1'b1;
  localparam logic RW_READ       = 1'b1;
  localparam logic RW_WRITE      = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              strb;
    logic [DATA_W-1:0] data;
  } bus_fields_t;

  // Idle bus: no strobe, read direction, zero address/data.
  localparam bus_fields_t BUS_IDLE = '{
    addr: '0,
    rw:   RW_READ,
    strb: AS_DISABLE,
    data: '0
  };

endpackage

// File: rtl/bus_master_mux.sv
// Master-side bus mux: forwards addr/rw/as/data of the granted master
// (fixed priority m0 > m1 > m2 > m3, grants active-low) onto the shared
// bus. Idle values when nobody is granted. OUT_REG=1 adds one register
// stage with async active-high reset; OUT_REG=0 is purely combinational.
// Ports: clk, reset; m0..m3 _addr/_rw/_as/_grant/_data; m_addr, m_rw,
// m_as, m_data (shared bus outputs).
module bus_master_mux
  import bus_master_mux_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic              m2_rw,
  input  logic              m3_rw,
  input  logic              m0_as,
  input  logic              m1_as,
  input  logic              m2_as,
  input  logic              m3_as,
  input  logic              m0_grant,
  input  logic              m1_grant,
  input  logic              m2_grant,
  input  logic              m3_grant,
  input  logic [DATA_W-1:0] m0_data,
  input  logic [DATA_W-1:0] m1_data,
  input  logic [DATA_W-1:0] m2_data,
  input  logic [DATA_W-1:0] m3_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rw,
  output logic              m_as,
  output logic [DATA_W-1:0] m_data
);

  bus_fields_t bus_d;
  bus_fields_t bus_o;

  // Whole bundle taken from one master so fields never mix; the
  // priority chain keeps multiple grants deterministic.
  always_comb begin
    bus_d = BUS_IDLE;
    if (m0_grant == GRANT_ENABLE) begin
      bus_d = '{m0_addr, m0_rw, m0_as, m0_data};
    end else if (m1_grant == GRANT_ENABLE) begin
      bus_d = '{m1_addr, m1_rw, m1_as, m1_data};
    end else if (m2_grant == GRANT_ENABLE) begin
      bus_d = '{m2_addr, m2_rw, m2_as, m2_data};
    end else if (m3_grant == GRANT_ENABLE) begin
      bus_d = '{m3_addr, m3_rw, m3_as, m3_data};
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      bus_fields_t bus_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bus_q <= BUS_IDLE;
        end else begin
          bus_q <= bus_d;
        end
      end

      assign bus_o = bus_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign bus_o = bus_d;
    end
  endgenerate

  assign m_addr = bus_o.addr;
  assign m_rw   = bus_o.rw;
  assign m_as   = bus_o.strb;
  assign m_data = bus_o.data;

endmodule

// File: tb/tb_bus_master_mux.sv
// Directed + random checks of bus_master_mux, registered and
// combinational builds, against a priority-select reference model.
module tb_bus_master_mux;

  logic        clk;
  logic        reset;
  logic [29:0] addr  [4];
  logic        rw    [4];
  logic        as_n  [4];
  logic        gnt   [4];
  logic [31:0] data  [4];

  logic [29:0] m_addr, c_addr;
  logic        m_rw, c_rw;
  logic        m_as, c_as;
  logic [31:0] m_data, c_data;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] IDLE = {30'd0, 1'b1, 1'b1, 32'd0};

  bus_master_mux #(.OUT_REG(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m2_addr(addr[2]), .m3_addr(addr[3]),
    .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
    .m0_as(as_n[0]), .m1_as(as_n[1]),
    .m2_as(as_n[2]), .m3_as(as_n[3]),
    .m0_grant(gnt[0]), .m1_grant(gnt[1]),
    .m2_grant(gnt[2]), .m3_grant(gnt[3]),
    .m0_data(data[0]), .m1_data(data[1]),
    .m2_data(data[2]), .m3_data(data[3]),
    .m_addr(m_addr), .m_rw(m_rw), .m_as(m_as), .m_data(m_data)
  );

  bus_master_mux #(.OUT_REG(1'b0)) u_comb (
    .clk(clk), .reset(reset),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m2_addr(addr[2]), .m3_addr(addr[3]),
    .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
    .m0_as(as_n[0]), .m1_as(as_n[1]),
    .m2_as(as_n[2]), .m3_as(as_n[3]),
    .m0_grant(gnt[0]), .m1_grant(gnt[1]),
    .m2_grant(gnt[2]), .m3_grant(gnt[3]),
    .m0_data(data[0]), .m1_data(data[1]),
    .m2_data(data[2]), .m3_data(data[3]),
    .m_addr(c_addr), .m_rw(c_rw), .m_as(c_as), .m_data(c_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model();
    for (int i = 0; i < 4; i++) begin
      if (gnt[i] === 1'b0) return {addr[i], rw[i], as_n[i], data[i]};
    end
    return IDLE;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [63:0] exp);
    chk(tag, {m_addr, m_rw, m_as, m_data}, exp);
  endtask

  task automatic chk_comb(input string tag, input logic [63:0] exp);
    chk(tag, {c_addr, c_rw, c_as, c_data}, exp);
  endtask

  task automatic set_m(input int i, input logic [29:0] a,
                       input logic r, input logic s,
                       input logic g, input logic [31:0] d);
    addr[i] = a; rw[i] = r; as_n[i] = s; gnt[i] = g; data[i] = d;
  endtask

  initial begin
    logic [63:0] exp;

    // reset with every master granted and strobing
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_m(i, 30'(i + 7), 1'b0, 1'b0, 1'b0, 32'(i + 9));
    repeat (2) @(posedge clk);
    #1;
    chk_reg("reset_idle", IDLE);
    chk_comb("comb_during_reset", {30'd7, 1'b0, 1'b0, 32'd9});
    reset = 1'b0;

    // single grant on m2
    for (int i = 0; i < 4; i++) set_m(i, 30'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    set_m(2, 30'd3, 1'b0, 1'b0, 1'b0, 32'd3);
    #1;
    chk_comb("comb_m2", {30'd3, 1'b0, 1'b0, 32'd3});
    @(posedge clk); #1;
    chk_reg("single_m2", {30'd3, 1'b0, 1'b0, 32'd3});

    // all granted: m0 wins
    for (int i = 0; i < 4; i++) set_m(i, 30'(i + 1), 1'b0, 1'b0, 1'b0, 32'(i + 1));
    rw[0] = 1'b1;
    @(posedge clk); #1;
    chk_reg("prio_m0", {30'd1, 1'b1, 1'b0, 32'd1});
    gnt[0] = 1'b1;
    #1;
    chk_reg("latency_hold", {30'd1, 1'b1, 1'b0, 32'd1});
    chk_comb("comb_m1", {30'd2, 1'b0, 1'b0, 32'd2});
    @(posedge clk); #1;
    chk_reg("prio_m1", {30'd2, 1'b0, 1'b0, 32'd2});

    // no grant -> idle
    for (int i = 0; i < 4; i++) gnt[i] = 1'b1;
    @(posedge clk); #1;
    chk_reg("no_grant", IDLE);
    chk_comb("comb_no_grant", IDLE);

    // granted m3 with strobe disabled, all-ones fields
    set_m(3, 30'h3fff_ffff, 1'b1, 1'b1, 1'b0, 32'hffff_ffff);
    @(posedge clk); #1;
    chk_reg("m3_as_off", {30'h3fff_ffff, 1'b1, 1'b1, 32'hffff_ffff});

    // unknowns on non-selected masters
    set_m(0, 30'h2aaa_aaaa, 1'b0, 1'b0, 1'b0, 32'h5555_aaaa);
    for (int i = 1; i < 4; i++) set_m(i, 'x, 1'bx, 1'bx, 1'bx, 'x);
    @(posedge clk); #1;
    chk_reg("x_isolation", {30'h2aaa_aaaa, 1'b0, 1'b0, 32'h5555_aaaa});

    // async reset mid-transfer while m1 owns the bus
    for (int i = 0; i < 4; i++) set_m(i, 30'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    set_m(1, 30'd5, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    chk_reg("m1_owns", {30'd5, 1'b0, 1'b0, 32'h1234_5678});
    #2 reset = 1'b1;
    #1;
    chk_reg("async_reset", IDLE);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk_reg("post_reset_load", {30'd5, 1'b0, 1'b0, 32'h1234_5678});

    // random grants vs. model
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 4; i++) begin
        set_m(i, 30'($urandom), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              32'($urandom));
      end
      exp = model();
      #1;
      chk_comb("rand_comb", exp);
      @(posedge clk); #1;
      chk_reg("rand_reg", exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
